// File: rtl/asic_clk_divider.sv
// asic_clk_divider: two-stage synchronous clock divider.
// Stage 1 is a prescaler that ticks every (divN+1) cycles, or every cycle when
// bypassed, and toggles a 50%-duty divided clock on each tick. Stage 2 counts
// prescaler ticks and emits a one-cycle clock-enable pulse every (divM+1)
// ticks. Everything runs in the single clk domain, and both outputs come
// straight from flops.
module asic_clk_divider #(
    parameter int p_divN_bits = 1,
    parameter int p_divM_bits = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en_divN,
    input  logic [p_divN_bits-1:0] divN,
    input  logic [p_divM_bits-1:0] divM,
    output logic                   clk_prescale_o,
    output logic                   clk_gate_o
);

    // Prescaler state. r_divN_act holds the divisor for the current period.
    logic [p_divN_bits-1:0] r_cntN;
    logic [p_divN_bits-1:0] r_divN_act;

    // Gate-stage state. r_divM_act holds the divisor for the current gate period.
    logic [p_divM_bits-1:0] r_cntM;
    logic [p_divM_bits-1:0] r_divM_act;

    // Output flops.
    logic r_clk_prescale;
    logic r_clk_gate;

    // Prescaler tick. In bypass it fires every cycle. When enabled it fires
    // when the counter reaches the active limit.
    logic w_tickN;
    assign w_tickN = en_divN ? (r_cntN == r_divN_act) : 1'b1;

    // Prescaler counter. A new divN is captured only at a period boundary, or
    // continuously while bypassed, so a smaller value can never strand the
    // counter above its limit.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, regardless of statement order.
        if (reset) begin
            r_cntN     <= '0;
            r_divN_act <= divN;
        end else if (!en_divN || w_tickN) begin
            r_cntN     <= '0;
            r_divN_act <= divN;
        end else begin
            r_cntN     <= r_cntN + 1'b1;
        end
    end

    // Divided clock. It toggles once per prescaler tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_prescale <= 1'b0;
        end else if (w_tickN) begin
            r_clk_prescale <= ~r_clk_prescale;
        end
    end

    // Gate stage. It advances only on prescaler ticks and pulses on the
    // terminal tick. The pulse lasts one cycle, because any cycle without a
    // tick clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cntM     <= '0;
            r_divM_act <= divM;
            r_clk_gate <= 1'b0;
        end else if (w_tickN) begin
            if (r_cntM == r_divM_act) begin
                r_cntM     <= '0;
                r_divM_act <= divM;
                r_clk_gate <= 1'b1;
            end else begin
                r_cntM     <= r_cntM + 1'b1;
                r_clk_gate <= 1'b0;
            end
        end else begin
            r_clk_gate <= 1'b0;
        end
    end

    assign clk_prescale_o = r_clk_prescale;
    assign clk_gate_o     = r_clk_gate;

endmodule

// File: tb/tb_asic_clk_divider.sv
// tb_asic_clk_divider: self-checking bench for asic_clk_divider.
// A cycle-level reference model pushes the expected outputs for each edge into
// a scoreboard queue, and those values are popped and compared after the edge.
// Pulse and toggle spacings, and the latency from reset release to the first
// pulse, are also checked against fixed values derived from the divide ratios.
module tb_asic_clk_divider;

    localparam int NB = 1;
    localparam int MB = 3;

    logic          clk;
    logic          reset;
    logic          en_divN;
    logic [NB-1:0] divN;
    logic [MB-1:0] divM;
    logic          clk_prescale_o;
    logic          clk_gate_o;

    asic_clk_divider #(
        .p_divN_bits(NB),
        .p_divM_bits(MB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .en_divN        (en_divN),
        .divN           (divN),
        .divM           (divM),
        .clk_prescale_o (clk_prescale_o),
        .clk_gate_o     (clk_gate_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic pre;
        logic gate;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [NB-1:0] m_cntN, m_divN_act;
    logic [MB-1:0] m_cntM, m_divM_act;
    logic          m_pre, m_gate;

    // Measurement bookkeeping.
    int   cyc = 0;
    bit   measure = 0;
    int   last_gate, last_tog;
    int   exp_gate_gap, exp_tog_gap;
    logic prev_pre = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance the model by one edge using the inputs about to be applied.
    task automatic model_step(input logic rst, input logic en,
                              input logic [NB-1:0] dn, input logic [MB-1:0] dm);
        logic tick;
        if (rst) begin
            m_cntN = '0; m_divN_act = dn;
            m_cntM = '0; m_divM_act = dm;
            m_pre  = 1'b0; m_gate = 1'b0;
        end else begin
            tick = en ? (m_cntN == m_divN_act) : 1'b1;
            if (tick) m_pre = ~m_pre;
            if (tick) begin
                if (m_cntM == m_divM_act) begin
                    m_cntM = '0; m_divM_act = dm; m_gate = 1'b1;
                end else begin
                    m_cntM = m_cntM + 1'b1; m_gate = 1'b0;
                end
            end else begin
                m_gate = 1'b0;
            end
            if (!en || tick) begin
                m_cntN = '0; m_divN_act = dn;
            end else begin
                m_cntN = m_cntN + 1'b1;
            end
        end
    endtask

    // Drive one cycle of stimulus, push the expected outputs, then compare
    // after the edge.
    task automatic step(input logic rst, input logic en,
                        input logic [NB-1:0] dn, input logic [MB-1:0] dm);
        exp_t e;
        reset = rst; en_divN = en; divN = dn; divM = dm;
        model_step(rst, en, dn, dm);
        e.pre  = m_pre;
        e.gate = m_gate;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check("clk_prescale_o", clk_prescale_o, e.pre);
            check("clk_gate_o", clk_gate_o, e.gate);
        end
        if (measure) begin
            if (clk_gate_o === 1'b1) begin
                if (last_gate >= 0) check("gate_gap", cyc - last_gate, exp_gate_gap);
                last_gate = cyc;
            end
            if (clk_prescale_o !== prev_pre) begin
                if (last_tog >= 0) check("toggle_gap", cyc - last_tog, exp_tog_gap);
                last_tog = cyc;
            end
        end
        prev_pre = clk_prescale_o;
    endtask

    // Let the configuration settle, then measure pulse and toggle spacing.
    task automatic run_measured(input logic en, input logic [NB-1:0] dn,
                                input logic [MB-1:0] dm, input int gg, input int tg);
        repeat (20) step(1'b0, en, dn, dm);
        exp_gate_gap = gg;
        exp_tog_gap  = tg;
        last_gate    = -1;
        last_tog     = -1;
        measure      = 1;
        repeat (40) step(1'b0, en, dn, dm);
        measure      = 0;
    endtask

    initial begin
        int first;
        reset = 1'b1; en_divN = 1'b0; divN = '0; divM = '0;

        // Reset held for two cycles: both outputs low.
        step(1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b0, 1'b0, 3'd0);
        check("rst_prescale", clk_prescale_o, 1'b0);
        check("rst_gate", clk_gate_o, 1'b0);

        // Bypass with divM=0: the gate is high from the first edge, and the
        // prescaled clock toggles every cycle.
        step(1'b0, 1'b0, 1'b0, 3'd0);
        check("bypass_first_gate", clk_gate_o, 1'b1);
        check("bypass_first_toggle", clk_prescale_o, 1'b1);
        run_measured(1'b0, 1'b0, 3'd0, 1, 1);

        // Enabled ratios.
        run_measured(1'b1, 1'b1, 3'd0, 2, 2);
        run_measured(1'b1, 1'b0, 3'd4, 5, 1);
        run_measured(1'b1, 1'b1, 3'd4, 10, 2);

        // Mid-period change from divN=1, divM=0 to divN=0, divM=4.
        repeat (7) step(1'b0, 1'b1, 1'b1, 3'd0);
        run_measured(1'b1, 1'b0, 3'd4, 5, 1);

        // Toggle the enable mid-period in both directions.
        repeat (3) step(1'b0, 1'b1, 1'b1, 3'd3);
        repeat (3) step(1'b0, 1'b0, 1'b1, 3'd3);
        repeat (9) step(1'b0, 1'b1, 1'b1, 3'd3);

        // Reset mid-period with divM=7. The first pulse comes after a full
        // (1+1)*(7+1) = 16 cycles.
        repeat (5) step(1'b0, 1'b1, 1'b1, 3'd7);
        step(1'b1, 1'b1, 1'b1, 3'd7);
        check("midrst_prescale", clk_prescale_o, 1'b0);
        check("midrst_gate", clk_gate_o, 1'b0);
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            step(1'b0, 1'b1, 1'b1, 3'd7);
            if (first < 0 && clk_gate_o === 1'b1) first = k;
        end
        check("first_pulse_after_reset", first, 16);

        // Random stress against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 5) != 0),
                 NB'($urandom), MB'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
